serial_subtractor: RTL

Bit-serial two's-complement subtractor, the inverse-direction companion to the team's ripple-carry adder datapath. It computes sub_out = input_1 - input_2 - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It has a valid/ready handshake on both the operand side and the result side, so the ALU control can issue a subtraction and collect the result with back-pressure.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: sub_out = input_1 - input_2 - bin, LSB first,
// one full-subtractor cell per clock. Define SUB_SIGNED_OVF_EN for signed overflow reporting.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sub_out,
  output logic             bout,
  output logic             sub_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] sub_out_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             bout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic a_bit;
  logic b_bit;
  logic diff_d;
  logic borrow_d;
  logic ovf_d;

  // Minuend doubles as the result shift register: difference bits enter at the MSB
  // as operand bits leave at the LSB, so after WIDTH shifts it holds the result.
  assign a_bit    = op1_q[0];
  assign b_bit    = op2_q[0];
  assign diff_d   = a_bit ^ b_bit ^ borrow_q;
  assign borrow_d = (~a_bit & b_bit) | (~a_bit & borrow_q) | (b_bit & borrow_q);

`ifdef SUB_SIGNED_OVF_EN
  logic msb1_q;
  logic msb2_q;

  // Operand sign bits are captured at acceptance because the shift registers lose them.
  assign ovf_d = (msb1_q ^ msb2_q) & (msb1_q ^ diff_d);
`else
  assign ovf_d = borrow_d;
`endif

  // NOTE: every register here uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked block.
    if (!rst_n) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      sub_out_q   <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      msb1_q      <= 1'b0;
      msb2_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op1_q      <= input_1;
            op2_q      <= input_2;
            borrow_q   <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef SUB_SIGNED_OVF_EN
            msb1_q     <= input_1[WIDTH-1];
            msb2_q     <= input_2[WIDTH-1];
`endif
          end
        end
        RUN: begin
          op1_q    <= {diff_d, op1_q[WIDTH-1:1]};
          op2_q    <= {1'b0, op2_q[WIDTH-1:1]};
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            sub_out_q   <= {diff_d, op1_q[WIDTH-1:1]};
            bout_q      <= borrow_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign sub_out      = sub_out_q;
  assign bout         = bout_q;
  assign sub_overflow = ovf_q;

endmodule
